cic_comb_sequencer: RTL and testbench



---
 rtl/cic_comb_sequencer_pkg.sv | 17 +
 rtl/cic_comb_sequencer_if.sv | 16 +
 rtl/cic_comb_sequencer.sv | 81 ++++++++
 tb/tb_cic_comb_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cic_comb_sequencer_pkg.sv
// cic_pkg: state encoding and sizing helpers shared by the CIC comb sequencer files
package cic_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;
   localparam int CHANNELS_DEF = 8;
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int frame_len(input int n);
      return 2 * n + 1;
   endfunction
   localparam int FRAME_LEN = frame_len(CHANNELS_DEF);
endpackage

// File: rtl/cic_comb_sequencer_if.sv
// cic_comb_sequencer_if: comb-side control bundle driven by the sequencer (master) into the comb/FIR path (slave)
interface cic_comb_sequencer_if
   import cic_pkg::*;
#(
   parameter int CHANNELS = 8
);
   localparam int CW = ch_width(CHANNELS);
   logic          comb_read_en;
   logic          comb_wr_en;
   logic [CW-1:0] comb_channel;
   logic [CW-1:0] src_channel;
   logic          out_valid;
   logic [CW-1:0] out_channel;
   modport master (output comb_read_en, comb_wr_en, comb_channel, src_channel, out_valid, out_channel);
   modport slave  (input  comb_read_en, comb_wr_en, comb_channel, src_channel, out_valid, out_channel);
endinterface

// File: rtl/cic_comb_sequencer.sv
// cic_comb_sequencer: walks every channel through a READ/WRITE pair per decimation tick; optional CIC_SEQ_OVERRUN_CNT_EN adds a saturating overrun counter
module cic_comb_sequencer
   import cic_pkg::*;
#(
   parameter int CHANNELS = 8
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        enable,
   input  logic                        start,
   input  logic                        overrun_clr,
   cic_comb_sequencer_if.master        bus,
   output logic                        busy,
   output logic                        done,
   output logic                        overrun
`ifdef CIC_SEQ_OVERRUN_CNT_EN
   ,
   output logic [7:0]                  overrun_count
`endif
);
   localparam int            CW   = ch_width(CHANNELS);
   localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
   state_t        r_state, w_next;
   logic [CW-1:0] r_ch, w_ch_next;
   logic          r_overrun;
   logic          w_in_sweep, w_go, w_discard;
   assign w_in_sweep = (r_state == S_READ) || (r_state == S_WRITE);
   assign w_go       = start && enable;
   assign w_discard  = start && w_in_sweep;
   // next state and channel: a sweep restarts at channel 0 only from IDLE or DONE
   always_comb begin
      w_next    = r_state;
      w_ch_next = r_ch;
      case (r_state)
         S_IDLE:  begin
            w_next    = w_go ? S_READ : S_IDLE;
            w_ch_next = w_go ? '0 : r_ch;
         end
         S_READ:  w_next = S_WRITE;
         S_WRITE: begin
            w_next    = (r_ch == LAST) ? S_DONE : S_READ;
            w_ch_next = (r_ch == LAST) ? r_ch : r_ch + CW'(1);
         end
         default: begin
            w_next    = w_go ? S_READ : S_IDLE;
            w_ch_next = w_go ? '0 : r_ch;
         end
      endcase
   end
   // state, channel and sticky overrun (a new overrun beats a same-cycle clear)
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_state   <= S_IDLE;
         r_ch      <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_ch      <= w_ch_next;
         r_overrun <= (w_discard && enable) || (r_overrun && !overrun_clr);
      end
   end
   assign bus.comb_read_en = (r_state == S_READ);
   assign bus.comb_wr_en   = (r_state == S_WRITE);
   assign bus.comb_channel = w_in_sweep ? r_ch : '0;
   assign bus.src_channel  = w_in_sweep ? r_ch : '0;
   assign bus.out_valid    = (r_state == S_WRITE);
   assign bus.out_channel  = (r_state == S_WRITE) ? r_ch : '0;
   assign busy             = w_in_sweep;
   assign done             = (r_state == S_DONE);
   assign overrun          = r_overrun;
`ifdef CIC_SEQ_OVERRUN_CNT_EN
   logic [7:0] r_cnt;
   // saturating count of starts discarded mid-sweep; clear has priority over increment
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn)                         r_cnt <= '0;
      else if (overrun_clr)               r_cnt <= '0;
      else if (w_discard && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
   end
   assign overrun_count = r_cnt;
`endif
endmodule

// File: tb/tb_cic_comb_sequencer.sv
// tb_cic_comb_sequencer: scoreboard bench comparing the sequencer against a sweep-level reference model
module tb_cic_comb_sequencer;
   import cic_pkg::*;
   localparam int N = 8;
   typedef struct {int cyc; int ch;} ev_t;
   logic clk = 1'b0, resetn = 1'b1, enable = 1'b0, start = 1'b0, overrun_clr = 1'b0;
   logic busy, done, overrun;
   logic [7:0] overrun_count;
   int cyc = 0, checks = 0, errors = 0;
   int busy_lo = 0, busy_end = -1;
   logic exp_ovr = 1'b0;
   int exp_cnt = 0;
   ev_t rd_q[$], wr_q[$], dn_q[$];
   cic_comb_sequencer_if #(.CHANNELS(N)) bus();
   cic_comb_sequencer #(.CHANNELS(N)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .start(start), .overrun_clr(overrun_clr),
      .bus(bus), .busy(busy), .done(done), .overrun(overrun)
`ifdef CIC_SEQ_OVERRUN_CNT_EN
      , .overrun_count(overrun_count)
`endif
   );
`ifndef CIC_SEQ_OVERRUN_CNT_EN
   assign overrun_count = 8'd0;
`endif
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endfunction
   // reference model: a sweep accepted at cycle c reads channel k at c+1+2k, writes it at c+2+2k, done at c+2N+1
   function automatic void accept(int c);
      for (int k = 0; k < N; k++) begin
         rd_q.push_back('{c + 1 + 2 * k, k});
         wr_q.push_back('{c + 2 + 2 * k, k});
      end
      dn_q.push_back('{c + 2 * N + 1, 0});
      busy_lo  = c + 1;
      busy_end = c + 2 * N;
   endfunction
   task automatic step(input logic s, input logic en, input logic clr);
      int  c;
      logic disc;
      start = s; enable = en; overrun_clr = clr; c = cyc;
      @(posedge clk); #1;
      disc = s && c >= busy_lo && c <= busy_end;
      if (!disc && s && en) accept(c);
      exp_ovr = (disc && en) || (exp_ovr && !clr);
      exp_cnt = clr ? 0 : (disc && exp_cnt < 255) ? exp_cnt + 1 : exp_cnt;
   endtask
   task automatic idle(input int n, input logic en);
      repeat (n) step(1'b0, en, 1'b0);
   endtask
   task automatic do_reset();
      resetn = 1'b1; #1;
      chk("rst_read_en", bus.comb_read_en, 0);
      chk("rst_wr_en", bus.comb_wr_en, 0);
      chk("rst_comb_ch", bus.comb_channel, 0);
      chk("rst_src_ch", bus.src_channel, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_ch", bus.out_channel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_count", overrun_count, 0);
      resetn = 1'b0;
      rd_q.delete(); wr_q.delete(); dn_q.delete();
      busy_lo = 0; busy_end = -1; exp_ovr = 1'b0; exp_cnt = 0;
   endtask
   // monitor: per-cycle invariants plus in-order pops of expected read/write/done events
   always @(negedge clk) begin
      ev_t e;
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_end) ? 1 : 0);
      chk("overrun", overrun, exp_ovr);
      chk("rd_wr_excl", bus.comb_read_en & bus.comb_wr_en, 0);
`ifdef CIC_SEQ_OVERRUN_CNT_EN
      chk("overrun_count", overrun_count, exp_cnt);
`endif
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin e = rd_q.pop_front(); chk("read_missing_cyc", cyc, e.cyc); end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin e = wr_q.pop_front(); chk("write_missing_cyc", cyc, e.cyc); end
      while (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin e = dn_q.pop_front(); chk("done_missing_cyc", cyc, e.cyc); end
      if (bus.comb_read_en) begin
         if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            e = rd_q.pop_front();
            chk("read_ch", bus.comb_channel, e.ch);
            chk("read_src_ch", bus.src_channel, e.ch);
         end else chk("read_unexpected_cyc", cyc, rd_q.size() > 0 ? rd_q[0].cyc : -1);
      end
      if (bus.out_valid) begin
         if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
            e = wr_q.pop_front();
            chk("write_en", bus.comb_wr_en, 1);
            chk("out_ch", bus.out_channel, e.ch);
            chk("write_ch", bus.comb_channel, e.ch);
            chk("write_src_ch", bus.src_channel, e.ch);
         end else chk("write_unexpected_cyc", cyc, wr_q.size() > 0 ? wr_q[0].cyc : -1);
      end else if (bus.comb_wr_en) chk("wr_en_without_valid", bus.out_valid, 1);
      if (done) begin
         if (dn_q.size() > 0 && dn_q[0].cyc == cyc) begin
            e = dn_q.pop_front();
            chk("done_busy", busy, 0);
         end else chk("done_unexpected_cyc", cyc, dn_q.size() > 0 ? dn_q[0].cyc : -1);
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      idle(5, 1'b1);
      // single sweep
      step(1'b1, 1'b1, 1'b0); idle(20, 1'b1);
      // back-to-back: second start lands on the DONE cycle
      step(1'b1, 1'b1, 1'b0); idle(2 * N, 1'b1); step(1'b1, 1'b1, 1'b0); idle(20, 1'b1);
      // overrun mid-sweep, then clear
      step(1'b1, 1'b1, 1'b0); idle(4, 1'b1); step(1'b1, 1'b1, 1'b0); idle(15, 1'b1);
      step(1'b0, 1'b1, 1'b1); idle(3, 1'b1);
      // enable low: ignored start, then enable dropped during a sweep with a start that must not flag
      step(1'b1, 1'b0, 1'b0); idle(20, 1'b0);
      step(1'b1, 1'b1, 1'b0); idle(5, 1'b0); step(1'b1, 1'b0, 1'b0); idle(15, 1'b0);
      step(1'b0, 1'b1, 1'b1); idle(2, 1'b1);
      // reset mid-sweep, restart from channel 0
      step(1'b1, 1'b1, 1'b0); idle(7, 1'b1); do_reset(); idle(3, 1'b1);
      step(1'b1, 1'b1, 1'b0); idle(20, 1'b1);
      // randomized traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0);
      idle(20, 1'b1);
      step(1'b0, 1'b1, 1'b1); idle(2, 1'b1);
`ifdef CIC_SEQ_OVERRUN_CNT_EN
      // continuous starts: enough discards to saturate the counter
      repeat (300) step(1'b1, 1'b1, 1'b0);
      idle(20, 1'b1);
      chk("count_saturated", overrun_count, 255);
      step(1'b0, 1'b1, 1'b1);
      chk("count_cleared", overrun_count, 0);
      idle(2, 1'b1);
`endif
      chk("read_q_drained", rd_q.size(), 0);
      chk("write_q_drained", wr_q.size(), 0);
      chk("done_q_drained", dn_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
